draw_board: RTL and testbench

Renders the locked-in Tetris board: a 10×20 grid of 35-pixel cells whose contents come from an external synchronous board RAM. It sits in the VGA pixel chain directly upstream of the falling-piece drawer, between the background stage and `draw_rect`. Each occupied cell is drawn with the same three-pixel bevel style as the falling piece, so settled blocks and the live block look identical. Empty cells and off-board pixels pass `rgb_in` through.

---
 rtl/draw_board.sv | 181 ++++++++++++++++++
 tb/tb_draw_board.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_board.sv
// Locked-in Tetris board renderer: overlays a 10x20 grid of bevelled cells, read from an
// external single-cycle synchronous board RAM, onto the VGA pixel stream with 2-cycle latency.
module draw_board #(
  parameter int BOARD_X = 201,
  parameter int BOARD_Y = 10,
  parameter int CELL    = 35,
  parameter int COLS    = 10,
  parameter int ROWS    = 20
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  board_addr,
  input  logic [2:0]  board_data,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] BX        = 11'(BOARD_X);
  localparam logic [10:0] BY        = 11'(BOARD_Y);
  localparam logic [3:0]  COL_END   = 4'(COLS);
  localparam logic [4:0]  ROW_END   = 5'(ROWS);
  localparam logic [5:0]  CELL_LAST = 6'(CELL - 1);
  localparam logic [5:0]  DARK_FROM = 6'(CELL - 4);
  localparam logic [5:0]  BEVEL     = 6'd3;
  localparam logic [6:0]  DIAG      = 7'(CELL - 1);

  // stage 1
  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic [3:0]  col;
  logic [5:0]  xoff;
  logic [4:0]  row;
  logic [5:0]  yoff;
  logic        inb_s1;
  logic [7:0]  row_ext;

  // stage 2
  logic [11:0] rgb_s2;
  logic        inb_s2;
  logic [5:0]  xoff_s2, yoff_s2;

  // pixel colour
  logic [11:0] base, bright, dark;
  logic [6:0]  diag_sum;
  logic [11:0] rgb_out_nxt;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
      col       <= COL_END;
      xoff      <= '0;
      row       <= ROW_END;
      yoff      <= '0;
    end else begin
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
      hblnk_s1  <= hblnk_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;

      if (hcount_in == 11'd0) begin
        col <= COL_END;
      end else if (hcount_in == BX) begin
        col  <= '0;
        xoff <= '0;
      end else if (col < COL_END) begin
        if (xoff == CELL_LAST) begin
          xoff <= '0;
          col  <= col + 4'd1;
        end else begin
          xoff <= xoff + 6'd1;
        end
      end

      // Rows advance once per line, at the line's first pixel.
      if (hcount_in == 11'd0) begin
        if (vcount_in == 11'd0) begin
          row <= ROW_END;
        end else if (vcount_in == BY) begin
          row  <= '0;
          yoff <= '0;
        end else if (row < ROW_END) begin
          if (yoff == CELL_LAST) begin
            yoff <= '0;
            row  <= row + 5'd1;
          end else begin
            yoff <= yoff + 6'd1;
          end
        end
      end
    end
  end

  assign inb_s1  = (col < COL_END) && (row < ROW_END);
  assign row_ext = {3'b000, row};
  // row*10 as row*8 + row*2
  assign board_addr = inb_s1 ? ((row_ext << 3) + (row_ext << 1) + {4'b0000, col}) : 8'd0;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_s2     <= '0;
      inb_s2     <= 1'b0;
      xoff_s2    <= '0;
      yoff_s2    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_s2     <= rgb_s1;
      inb_s2     <= inb_s1;
      xoff_s2    <= xoff;
      yoff_s2    <= yoff;
    end
  end

  always_comb begin
    base = 12'h000;
    case (board_data)
      3'd1:    base = 12'hF00;
      3'd2:    base = 12'h0F0;
      3'd3:    base = 12'h00F;
      3'd4:    base = 12'hFF0;
      3'd5:    base = 12'hF0F;
      3'd6:    base = 12'h0FF;
      3'd7:    base = 12'hF80;
      default: base = 12'h000;
    endcase
  end

  assign bright   = base | 12'h888;
  assign dark     = {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]};
  assign diag_sum = {1'b0, xoff_s2} + {1'b0, yoff_s2};

  always_comb begin
    rgb_out_nxt = base;
    if (hblnk_out || vblnk_out) begin
      rgb_out_nxt = 12'h000;
    end else if (!inb_s2 || board_data == 3'd0) begin
      rgb_out_nxt = rgb_s2;
    end else if ((xoff_s2 < BEVEL || yoff_s2 < BEVEL) && diag_sum < DIAG) begin
      rgb_out_nxt = bright;
    end else if (xoff_s2 > DARK_FROM || yoff_s2 > DARK_FROM) begin
      rgb_out_nxt = dark;
    end
  end

  // board_data lands with stage 2, so the final mux is left unregistered to keep the
  // pixel aligned with hcount_out/vcount_out at 2 cycles.
  assign rgb_out = rgb_out_nxt;

endmodule

// File: tb/tb_draw_board.sv
// Directed bench for draw_board: compressed raster lines, a synchronous RAM model and
// hand-computed pixel/address expectations checked 1-2 cycles after each driven pixel.
module tb_draw_board;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  board_addr;
  logic [2:0]  board_data = 3'd0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 pclk = ~pclk;

  draw_board dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .board_addr(board_addr), .board_data(board_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  logic [2:0] ram [0:199];
  always @(posedge pclk) board_data <= (board_addr < 8'd200) ? ram[board_addr] : 3'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit sweep = 1'b0;
  bit full_line [0:711];

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic        blank;
    logic [11:0] exp;
    int          addr;
    string       tag;
  } watch_t;

  exp_t   pend[$];
  watch_t watches[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0:       return {20'd0, rgb_out};
      1:       return {24'd0, board_addr};
      2:       return {21'd0, hcount_out};
      3:       return {21'd0, vcount_out};
      4:       return {31'd0, hsync_out};
      5:       return {31'd0, vsync_out};
      6:       return {31'd0, hblnk_out};
      default: return {31'd0, vblnk_out};
    endcase
  endfunction

  task automatic expect_at(input int lag, input int sel, input logic [31:0] exp, input string tag);
    exp_t e;
    e.due = cyc + lag;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    pend.push_back(e);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        check(pend[i].tag, probe(pend[i].sel), pend[i].exp);
        pend.delete(i);
      end
    end
  endtask

  function automatic int ref_addr(input int h, input int v);
    if (h >= 201 && h < 551 && v >= 10 && v < 710) return ((v - 10) / 35) * 10 + (h - 201) / 35;
    return 0;
  endfunction

  task automatic add_w(input int h, input int v, input logic blank, input logic [11:0] exp,
                       input int addr, input string tag);
    watch_t w;
    w.h = h; w.v = v; w.blank = blank; w.exp = exp; w.addr = addr; w.tag = tag;
    watches.push_back(w);
  endtask

  task automatic drive_px(input int h, input int v);
    logic blank;
    blank     = 1'b0;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = 12'h5A5;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    vblnk_in  = 1'b0;
    foreach (watches[i]) begin
      if (watches[i].h == h && watches[i].v == v) begin
        blank = watches[i].blank;
        expect_at(2, 0, {20'd0, watches[i].exp}, watches[i].tag);
        if (watches[i].addr >= 0) expect_at(1, 1, 32'(watches[i].addr), {watches[i].tag, "_addr"});
        if (watches[i].blank) begin
          expect_at(2, 6, 32'd1, {watches[i].tag, "_hblnk"});
          expect_at(2, 2, 32'(h), {watches[i].tag, "_hcount"});
        end
      end
    end
    hblnk_in = blank;
    if (sweep) begin
      expect_at(2, 0, 32'h5A5, "sweep_rgb");
      expect_at(1, 1, 32'(ref_addr(h, v)), "sweep_addr");
    end
    step();
  endtask

  task automatic run_frame();
    for (int v = 0; v < 712; v++) begin
      drive_px(0, v);
      if (full_line[v]) begin
        for (int h = 195; h <= 560; h++) drive_px(h, v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 200; i++) ram[i] = 3'd0;
    for (int v = 0; v < 712; v++) full_line[v] = 1'b0;

    // Reset held with nonzero inputs
    rst = 1'b0;
    hcount_in = 11'h123; vcount_in = 11'h045;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b1;
    rgb_in = 12'hABC;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_hcount", {21'd0, hcount_out}, 32'd0);
    check("rst_vcount", {21'd0, vcount_out}, 32'd0);
    check("rst_hsync", {31'd0, hsync_out}, 32'd0);
    check("rst_vsync", {31'd0, vsync_out}, 32'd0);
    check("rst_hblnk", {31'd0, hblnk_out}, 32'd0);
    check("rst_vblnk", {31'd0, vblnk_out}, 32'd0);
    check("rst_rgb", {20'd0, rgb_out}, 32'd0);
    check("rst_addr", {24'd0, board_addr}, 32'd0);
    rst = 1'b1;

    // Timing ramp: every output is the input two cycles earlier
    for (int h = 0; h < 16; h++) begin
      logic [3:0] hb;
      hb = 4'(h);
      hcount_in = 11'(h);
      vcount_in = 11'(h * 3 + 1);
      hsync_in = hb[0]; vsync_in = hb[1]; hblnk_in = hb[2]; vblnk_in = hb[3];
      rgb_in = 12'h5A5;
      expect_at(2, 2, 32'(h), "ramp_hcount");
      expect_at(2, 3, 32'(h * 3 + 1), "ramp_vcount");
      expect_at(2, 4, {31'd0, hb[0]}, "ramp_hsync");
      expect_at(2, 5, {31'd0, hb[1]}, "ramp_vsync");
      expect_at(2, 6, {31'd0, hb[2]}, "ramp_hblnk");
      expect_at(2, 7, {31'd0, hb[3]}, "ramp_vblnk");
      expect_at(2, 0, (hb[2] | hb[3]) ? 32'h000 : 32'h5A5, "ramp_rgb");
      step();
    end
    drive_px(0, 0);
    drive_px(0, 0);

    // Occupied-cell frame: first cell, last cell, bevel cell, blanking
    ram[0] = 3'd1; ram[199] = 3'd3; ram[12] = 3'd4;
    add_w(201, 10, 1'b0, 12'hF88, 0,   "s_bright");
    add_w(220, 20, 1'b0, 12'hF00, 0,   "s_base");
    add_w(235, 44, 1'b0, 12'h700, 0,   "s_dark");
    add_w(236, 20, 1'b0, 12'h5A5, 1,   "s_next_cell");
    add_w(200, 20, 1'b0, 12'h5A5, 0,   "s_left_of_board");
    add_w(516, 675, 1'b0, 12'h88F, 199, "l_bright");
    add_w(526, 685, 1'b0, 12'h00F, 199, "l_base");
    add_w(550, 709, 1'b0, 12'h007, 199, "l_dark");
    add_w(551, 709, 1'b0, 12'h5A5, 0,   "l_right_edge");
    add_w(550, 710, 1'b0, 12'h5A5, 0,   "l_bottom_edge");
    add_w(271, 45, 1'b0, 12'hFF8, 12,  "b_top_left");
    add_w(305, 45, 1'b0, 12'h770, 12,  "b_top_right");
    add_w(304, 46, 1'b0, 12'h770, 12,  "b_x33_y1");
    add_w(273, 76, 1'b0, 12'hFF8, 12,  "b_x2_y31");
    add_w(273, 77, 1'b0, 12'h770, 12,  "b_x2_y32");
    add_w(291, 65, 1'b0, 12'hFF0, 12,  "b_base");
    add_w(225, 15, 1'b1, 12'h000, 0,   "blank_cell");
    foreach (watches[i]) full_line[watches[i].v] = 1'b1;
    run_frame();

    // Empty-board frame with every driven pixel checked
    watches.delete();
    for (int i = 0; i < 200; i++) ram[i] = 3'd0;
    for (int v = 0; v < 712; v++) full_line[v] = 1'b0;
    full_line[10] = 1'b1; full_line[44] = 1'b1; full_line[45] = 1'b1;
    full_line[400] = 1'b1; full_line[709] = 1'b1; full_line[710] = 1'b1;
    sweep = 1'b1;
    run_frame();
    sweep = 1'b0;

    drive_px(0, 0);
    drive_px(0, 0);
    drive_px(0, 0);
    check("pending_drained", 32'(pend.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
